// File: rtl/store_queue.sv
// Post-commit store buffer: drains committed stores to memory in order and forwards
// buffered (and same-cycle incoming) store bytes to two load ports.
// Width encoding (RISC-V funct3 style): [2]=unsigned load, [1:0]=0 byte, 1 half, 2 word.
module store_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] wa,
  input  logic [31:0] wd,
  input  logic [2:0]  wm,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        mem_we,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_wm,
  input  logic        mem_ack,
  input  logic [31:0] la           [2],
  input  logic [2:0]  lm           [2],
  output logic        fwd_hit      [2],
  output logic [31:0] fwd_data     [2],
  output logic        fwd_conflict [2]
);
  localparam logic [DEPTH_LOG:0]   FullCount = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   CntOne    = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PtrOne    = DEPTH_LOG'(1);

  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG:0]   count;
  logic                 push, pop;

  logic [29:0] e_word [DEPTH];
  logic [3:0]  e_mask [DEPTH];
  logic [31:0] e_lane [DEPTH];
  logic [31:0] e_addr [DEPTH];
  logic [2:0]  e_mode [DEPTH];
  logic [31:0] e_data [DEPTH];

  logic [3:0]  in_mask;
  logic [31:0] in_lane;

  function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [2:0] mode);
    logic [6:0] m;
    case (mode[1:0])
      2'd0:    m = 7'b000_0001 << off;
      2'd1:    m = 7'b000_0011 << off;
      default: m = 7'b000_1111;
    endcase
    return m[3:0];
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FullCount);
  assign mem_we  = !empty;
  assign pop     = mem_we && mem_ack;
  assign push    = we && (!full || pop);
  assign in_mask = byte_mask(wa[1:0], wm);
  assign in_lane = wd << {wa[1:0], 3'b000};

  assign mem_wa = e_addr[head];
  assign mem_wd = e_data[head];
  assign mem_wm = e_mode[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PtrOne;
      if (pop)  head <= head + PtrOne;
      if (push && !pop)      count <= count + CntOne;
      else if (pop && !push) count <= count - CntOne;
      if (we && !push) overflow <= 1'b1;
    end
  end

  // Entry payload is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      e_word[tail] <= wa[31:2];
      e_mask[tail] <= in_mask;
      e_lane[tail] <= in_lane;
      e_addr[tail] <= wa;
      e_mode[tail] <= wm;
      e_data[tail] <= wd;
    end
  end

  always_comb begin : fwd
    logic [3:0]           lmask, sup, got;
    logic [31:0]          asm_word, shifted;
    logic [DEPTH_LOG-1:0] idx;
    for (int p = 0; p < 2; p++) begin
      lmask    = byte_mask(la[p][1:0], lm[p]);
      sup      = '0;
      asm_word = '0;
      // Walk oldest to youngest so younger stores overwrite older ones lane by lane.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = head + DEPTH_LOG'(k);
        if (((DEPTH_LOG+1)'(k) < count) && (e_word[idx] == la[p][31:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (e_mask[idx][b]) begin
              sup[b]            = 1'b1;
              asm_word[8*b +: 8] = e_lane[idx][8*b +: 8];
            end
          end
        end
      end
      if (push && (wa[31:2] == la[p][31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (in_mask[b]) begin
            sup[b]            = 1'b1;
            asm_word[8*b +: 8] = in_lane[8*b +: 8];
          end
        end
      end
      got             = sup & lmask;
      fwd_hit[p]      = (got == lmask);
      fwd_conflict[p] = (got != '0) && (got != lmask);
      shifted         = asm_word >> {la[p][1:0], 3'b000};
      fwd_data[p]     = '0;
      if (fwd_hit[p]) begin
        case (lm[p][1:0])
          2'd0:    fwd_data[p] = {{24{~lm[p][2] & shifted[7]}}, shifted[7:0]};
          2'd1:    fwd_data[p] = {{16{~lm[p][2] & shifted[15]}}, shifted[15:0]};
          default: fwd_data[p] = shifted;
        endcase
      end
    end
  end
endmodule
